fir_tap_sched: RTL



---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_mac_unit.sv | 44 ++++
 rtl/fir_tap_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR tap scheduler:
// default sizes, controller state encoding and a width sanity helper.
package fir_pkg;

    localparam int TAPS_DEF = 128;
    localparam int BW_DEF   = 16;
    localparam int ACCW_DEF = 40;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        MAC   = 2'd2
    } fir_state_e;

    // Full-precision product plus one growth bit per doubling of the tap count.
    function automatic int accw_min(input int bw, input int taps);
        return 2 * bw + $clog2(taps);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed BW x BW multiplier feeding a wrapping ACCW-bit accumulator.
// sum_o is the running total including the product presented this cycle.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int BW   = BW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic signed [BW-1:0]   coef_i,
    input  logic signed [BW-1:0]   sample_i,
    output logic signed [ACCW-1:0] sum_o
);

    logic signed [2*BW-1:0] prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;

    assign prod     = coef_i * sample_i;
    assign prod_ext = ACCW'(prod);
    assign sum_o    = acc_q + prod_ext;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_tap_sched.sv
// Time-multiplexed FIR controller: circular sample buffer, coefficient RAM
// and a CLEAR/IDLE/MAC sequencer driving a single shared MAC unit.
module fir_tap_sched
    import fir_pkg::*;
#(
    parameter int  TAPS = TAPS_DEF,
    parameter int  BW   = BW_DEF,
    parameter int  ACCW = ACCW_DEF,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [BW-1:0]   din,
    input  logic                   din_vld,
    output logic                   din_rdy,
    input  logic                   coef_we,
    input  logic [AW-1:0]          coef_addr,
    input  logic signed [BW-1:0]   coef_wdata,
    output logic signed [ACCW-1:0] dout,
    output logic                   dout_vld,
    output logic                   busy
);

    if (ACCW < accw_min(BW, TAPS)) begin : g_accw_check
        $error("fir_tap_sched: ACCW narrower than 2*BW+clog2(TAPS)");
    end
    if (!is_pow2(TAPS) || TAPS < 4) begin : g_taps_check
        $error("fir_tap_sched: TAPS must be a power of two and at least 4");
    end

    // Storage has no reset; the CLEAR sweep zeroes it so it can map to RAM.
    logic signed [BW-1:0] sample_mem [TAPS];
    logic signed [BW-1:0] coef_mem   [TAPS];

    fir_state_e             state_q;
    logic [AW-1:0]          k_q;
    logic [AW-1:0]          wptr_q;
    logic [AW-1:0]          newest_q;
    logic                   din_rdy_q;
    logic                   busy_q;
    logic                   dout_vld_q;
    logic signed [ACCW-1:0] dout_q;

    logic                   accept;
    logic                   last_tap;
    logic [AW-1:0]          rd_idx;
    logic signed [BW-1:0]   mac_coef;
    logic signed [BW-1:0]   mac_sample;
    logic signed [ACCW-1:0] mac_sum;

    assign accept   = din_rdy_q && din_vld;
    assign last_tap = (k_q == AW'(TAPS - 1));
    assign rd_idx   = newest_q - k_q;

    assign mac_coef   = coef_mem[k_q];
    assign mac_sample = sample_mem[rd_idx];

    fir_mac_unit #(
        .BW   (BW),
        .ACCW (ACCW)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (accept),
        .en_i     (state_q == MAC),
        .coef_i   (mac_coef),
        .sample_i (mac_sample),
        .sum_o    (mac_sum)
    );

    // A coefficient written alongside an accepted sample lands before the first MAC read.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            sample_mem[k_q] <= '0;
            coef_mem[k_q]   <= '0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                sample_mem[wptr_q] <= din;
            end
            if (coef_we) begin
                coef_mem[coef_addr] <= coef_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            k_q        <= '0;
            wptr_q     <= '0;
            newest_q   <= '0;
            din_rdy_q  <= 1'b0;
            busy_q     <= 1'b1;
            dout_vld_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            dout_vld_q <= 1'b0;
            unique case (state_q)
                CLEAR: begin
                    k_q <= k_q + AW'(1);
                    if (last_tap) begin
                        state_q   <= IDLE;
                        din_rdy_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        newest_q  <= wptr_q;
                        wptr_q    <= wptr_q + AW'(1);
                        k_q       <= '0;
                        state_q   <= MAC;
                        din_rdy_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                MAC: begin
                    k_q <= k_q + AW'(1);
                    if (last_tap) begin
                        dout_q     <= mac_sum;
                        dout_vld_q <= 1'b1;
                        state_q    <= IDLE;
                        din_rdy_q  <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    k_q       <= '0;
                    din_rdy_q <= 1'b0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign din_rdy  = din_rdy_q;
    assign busy     = busy_q;
    assign dout_vld = dout_vld_q;
    assign dout     = dout_q;

endmodule
